// File: rtl/rgb2gray_pkg.sv
// Shared defaults and derived widths for the RGB-to-grayscale pixel path.
package rgb2gray_pkg;

    localparam int unsigned DW_DEF     = 8;
    localparam int unsigned COEF_R_DEF = 77;
    localparam int unsigned COEF_G_DEF = 150;
    localparam int unsigned COEF_B_DEF = 29;
    localparam int unsigned FRAC_DEF   = 8;

    // Product of a DW-bit channel and an 8-bit weight.
    function automatic int unsigned prod_w(input int unsigned dw);
        return dw + 8;
    endfunction

    // Sum of three products; two extra bits cover the carries.
    function automatic int unsigned sum_w(input int unsigned dw);
        return dw + 10;
    endfunction

    localparam int unsigned PROD_W_DEF = prod_w(DW_DEF);
    localparam int unsigned SUM_W_DEF  = sum_w(DW_DEF);

endpackage

// File: rtl/rgb2gray_wsum.sv
// Weighted channel sum: S1 registers the three products, S2 registers their sum.
module rgb2gray_wsum
    import rgb2gray_pkg::*;
#(
    parameter  int unsigned DW     = rgb2gray_pkg::DW_DEF,
    parameter  int unsigned COEF_R = rgb2gray_pkg::COEF_R_DEF,
    parameter  int unsigned COEF_G = rgb2gray_pkg::COEF_G_DEF,
    parameter  int unsigned COEF_B = rgb2gray_pkg::COEF_B_DEF,
    localparam int unsigned PROD_W = prod_w(DW),
    localparam int unsigned SUM_W  = sum_w(DW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic [DW-1:0]    r_data,
    input  logic [DW-1:0]    g_data,
    input  logic [DW-1:0]    b_data,
    output logic             sum_valid,
    output logic [SUM_W-1:0] sum
);

    logic [PROD_W-1:0] p_r;
    logic [PROD_W-1:0] p_g;
    logic [PROD_W-1:0] p_b;
    logic              v1;

    // S1: data loads every cycle; v1 alone qualifies it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r <= '0;
            p_g <= '0;
            p_b <= '0;
            v1  <= 1'b0;
        end else begin
            p_r <= PROD_W'(r_data) * PROD_W'(COEF_R);
            p_g <= PROD_W'(g_data) * PROD_W'(COEF_G);
            p_b <= PROD_W'(b_data) * PROD_W'(COEF_B);
            v1  <= pix_valid;
        end
    end

    // S2: widened add, cannot overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum       <= SUM_W'(p_r) + SUM_W'(p_g) + SUM_W'(p_b);
            sum_valid <= v1;
        end
    end

endmodule

// File: rtl/rgb2gray.sv
// Streaming RGB-to-luma converter, three register stages, one pixel per clock.
module rgb2gray
    import rgb2gray_pkg::*;
#(
    parameter int unsigned DW     = rgb2gray_pkg::DW_DEF,
    parameter int unsigned COEF_R = rgb2gray_pkg::COEF_R_DEF,
    parameter int unsigned COEF_G = rgb2gray_pkg::COEF_G_DEF,
    parameter int unsigned COEF_B = rgb2gray_pkg::COEF_B_DEF,
    parameter int unsigned FRAC   = rgb2gray_pkg::FRAC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    input  logic [DW-1:0] r_data,
    input  logic [DW-1:0] g_data,
    input  logic [DW-1:0] b_data,
    output logic          dout_valid,
    output logic [DW-1:0] gray_data
);

    localparam int unsigned SUM_W = sum_w(DW);

    logic             v2;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] shifted_c;
    logic             sat_c;
    logic [DW-1:0]    gray_c;

    rgb2gray_wsum #(
        .DW     (DW),
        .COEF_R (COEF_R),
        .COEF_G (COEF_G),
        .COEF_B (COEF_B)
    ) u_wsum (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (din_valid),
        .r_data    (r_data),
        .g_data    (g_data),
        .b_data    (b_data),
        .sum_valid (v2),
        .sum       (sum)
    );

    // S3 datapath: truncating shift, clamp when the weights overshoot 2^FRAC.
    always_comb begin
        shifted_c = sum >> FRAC;
        sat_c     = |shifted_c[SUM_W-1:DW];
        gray_c    = sat_c ? {DW{1'b1}} : shifted_c[DW-1:0];
    end

    // Output stage: gray_data holds the last result across invalid cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid <= 1'b0;
            gray_data  <= '0;
        end else begin
            dout_valid <= v2;
            if (v2) begin
                gray_data <= gray_c;
            end
        end
    end

endmodule

// File: tb/tb_rgb2gray.sv
// Scoreboard bench for rgb2gray: default weights plus a saturating-weight instance.
module tb_rgb2gray;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic [7:0] r_data;
    logic [7:0] g_data;
    logic [7:0] b_data;
    logic       dout_valid;
    logic [7:0] gray_data;
    logic       dout_valid_s;
    logic [7:0] gray_data_s;

    typedef struct {
        int due;
        int gray;
        int gray_s;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   last   = 0;
    int   last_s = 0;

    rgb2gray dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .r_data     (r_data),
        .g_data     (g_data),
        .b_data     (b_data),
        .dout_valid (dout_valid),
        .gray_data  (gray_data)
    );

    rgb2gray #(.COEF_R(128), .COEF_G(128), .COEF_B(128)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .r_data     (r_data),
        .g_data     (g_data),
        .b_data     (b_data),
        .dout_valid (dout_valid_s),
        .gray_data  (gray_data_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic int luma(input int r, input int g, input int b,
                                input int cr, input int cg, input int cb);
        int y;
        y = (cr * r + cg * g + cb * b) / 256;
        return (y > 255) ? 255 : y;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit v, input int r, input int g, input int b);
        exp_t e;
        @(posedge clk);
        #1;
        din_valid = v;
        r_data    = 8'(r);
        g_data    = 8'(g);
        b_data    = 8'(b);
        if (v) begin
            e.due    = cyc + 3;
            e.gray   = luma(r, g, b, 77, 150, 29);
            e.gray_s = luma(r, g, b, 128, 128, 128);
            sb.push_back(e);
        end
    endtask

    // Monitor: pops the oldest expectation whenever the DUT presents a result.
    always @(negedge clk) begin
        if (!rst) begin
            if (dout_valid) begin
                if (sb.size() == 0) begin
                    chk("stale_valid", 32'(dout_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", 32'(cyc), 32'(e.due));
                    chk("gray", 32'(gray_data), 32'(e.gray));
                    chk("valid_sat", 32'(dout_valid_s), 32'd1);
                    chk("gray_sat", 32'(gray_data_s), 32'(e.gray_s));
                    last   = e.gray;
                    last_s = e.gray_s;
                end
            end else begin
                chk("hold", 32'(gray_data), 32'(last));
                chk("valid_sat_idle", 32'(dout_valid_s), 32'd0);
                chk("hold_sat", 32'(gray_data_s), 32'(last_s));
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    chk("missing_valid", 32'(dout_valid), 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int cr[6] = '{255, 0, 255, 128, 0, 0};
        int cg[6] = '{255, 0, 0, 128, 255, 0};
        int cb[6] = '{255, 0, 0, 128, 0, 255};
        bit gap[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int sent;

        rst       = 1'b1;
        din_valid = 1'b0;
        r_data    = '0;
        g_data    = '0;
        b_data    = '0;
        #1;
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_gray", 32'(gray_data), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Known colours back-to-back, then the gapped valid pattern.
        for (int i = 0; i < 6; i++) drive(1'b1, cr[i], cg[i], cb[i]);
        for (int i = 0; i < 5; i++) drive(gap[i], cr[i], cg[i], cb[i]);
        repeat (3) drive(1'b0, 0, 0, 0);

        // Reset while pixels are in flight.
        for (int i = 0; i < 4; i++)
            drive(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        @(posedge clk);
        #1;
        rst       = 1'b1;
        din_valid = 1'b0;
        sb.delete();
        last   = 0;
        last_s = 0;
        #1;
        chk("midrst_valid", 32'(dout_valid), 32'd0);
        chk("midrst_gray", 32'(gray_data), 32'd0);
        chk("midrst_valid_sat", 32'(dout_valid_s), 32'd0);
        chk("midrst_gray_sat", 32'(gray_data_s), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) drive(1'b0, 0, 0, 0);

        // Random sweep with sporadic gaps.
        sent = 0;
        while (sent < 10000) begin
            bit v;
            v = ($urandom_range(0, 9) < 8);
            drive(v, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            if (v) sent++;
        end
        repeat (4) drive(1'b0, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
